cpu_bus_master: RTL and testbench

CPU_BUS_MASTER -- requirements
Module: cpu_bus_master

---
 rtl/cpu_bus_master_if.sv | 27 ++
 rtl/cpu_bus_master.sv | 104 ++++++++++
 tb/tb_cpu_bus_master.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_master_if.sv
// cpu_bus_master_if: request/response handshake and bus strobe/address signals of cpu_bus_master
//   req_*       : request channel (valid/ready, write flag, 6-bit address, 16-bit write data)
//   rsp_*       : response channel (valid/ready, 16-bit read data, read-back error flag)
//   cpu_rd/wr   : active-high bus strobes; cpu_address: bus address
//   cpu_data is bidirectional and stays a plain port on the master.
interface cpu_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [5:0]  req_address;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [5:0]  cpu_address;
    modport master (
        input  req_valid, req_write, req_address, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, cpu_rd, cpu_wr, cpu_address
    );
    modport slave (
        output req_valid, req_write, req_address, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, cpu_rd, cpu_wr, cpu_address
    );
endinterface

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: turns one request into a timed setup/strobe/hold access on a shared register bus
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low
//   bus      : cpu_bus_master_if.master (request, response, strobes, address)
//   cpu_data : shared 16-bit bus data, driven only during a write access
//   Params   : SETUP_CYCLES (0..15), STROBE_CYCLES (1..15), HOLD_CYCLES (0..15)
//   Macro    : CPU_BUS_READBACK_EN -- each write is followed by a read of the same address,
//              rsp_rdata returns the read-back value and rsp_error flags a mismatch
module cpu_bus_master #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             reset,
    cpu_bus_master_if.master bus,
    inout  wire  [15:0]      cpu_data
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;
    localparam state_t FIRST = (SETUP_CYCLES != 0) ? SETUP : STROBE;
    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        write_q;
    logic [5:0]  addr_q;
    logic [15:0] wdata_q, rdata_q;
    logic        accept, last, active, access_end, again, rd_phase;
    assign accept     = bus.req_valid && bus.req_ready;
    assign last       = cnt == 4'd0;
    assign active     = state inside {SETUP, STROBE, HOLD};
    assign access_end = last && (state == HOLD || (state == STROBE && HOLD_CYCLES == 0));
`ifdef CPU_BUS_READBACK_EN
    logic rb_q, error_q;
    // again: the write half is done and its read-back access is still to come
    assign again         = write_q && !rb_q;
    assign rd_phase      = !write_q || rb_q;
    assign bus.rsp_error = error_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rb_q    <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (accept) begin
                rb_q    <= 1'b0;
                error_q <= 1'b0;
            end else if (access_end && again)
                rb_q <= 1'b1;
            if (state == STROBE && last && rb_q)
                error_q <= cpu_data != wdata_q;
        end
`else
    assign again         = 1'b0;
    assign rd_phase      = !write_q;
    assign bus.rsp_error = 1'b0;
`endif
    // Counter reload value for a state: it counts down to 0 on the state's last cycle.
    function automatic logic [3:0] load(input state_t s);
        return s == SETUP  ? 4'(SETUP_CYCLES - 1)  :
               s == STROBE ? 4'(STROBE_CYCLES - 1) :
               s == HOLD   ? 4'(HOLD_CYCLES - 1)   : 4'd0;
    endfunction
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = FIRST;
            SETUP:   if (last) state_nx = STROBE;
            STROBE:  if (last) state_nx = HOLD_CYCLES != 0 ? HOLD : again ? FIRST : RESP;
            HOLD:    if (last) state_nx = again ? FIRST : RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Every exit from an access state is a state entry (a zero-length restart included).
        cnt_nx = (accept || (active && last)) ? load(state_nx) : last ? 4'd0 : cnt - 4'd1;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            write_q <= 1'b0;
            addr_q  <= 6'd0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
        end else begin
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_address;
                wdata_q <= bus.req_wdata;
            end
            if (state == STROBE && last && rd_phase)
                rdata_q <= cpu_data;
        end
    assign bus.req_ready   = state == IDLE && reset;
    assign bus.rsp_valid   = state == RESP;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.cpu_rd      = state == STROBE && rd_phase;
    assign bus.cpu_wr      = state == STROBE && !rd_phase;
    assign bus.cpu_address = active ? addr_q : 6'd0;
    assign cpu_data        = (active && !rd_phase) ? wdata_q : 16'bz;
endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: directed scoreboard bench for cpu_bus_master (default timing and 0/1/0 timing)
module tb_cpu_bus_master;
`ifdef CPU_BUS_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    // Latency counted in edges from the accept edge (counted as 1) to the edge raising rsp_valid.
    localparam int WLAT = RB ? 9 : 5;
    typedef struct packed { logic [15:0] rdata; logic err; } rsp_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    cpu_bus_master_if if0();
    cpu_bus_master_if if1();
    // Pulled-up data buses: an undriven bus reads as 16'hFFFF.
    tri1 [15:0] data0;
    tri1 [15:0] data1;
    cpu_bus_master u0 (.clk(clk), .reset(reset), .bus(if0), .cpu_data(data0));
    cpu_bus_master #(.SETUP_CYCLES(0), .STROBE_CYCLES(1), .HOLD_CYCLES(0))
        u1 (.clk(clk), .reset(reset), .bus(if1), .cpu_data(data1));
    // Bus register on u0's bus: bit 0 is stuck at 0.
    logic [15:0] dev_reg = 16'd0;
    always @(posedge clk) if (if0.cpu_wr) dev_reg <= data0 & 16'hFFFE;
    assign data0 = if0.cpu_rd ? dev_reg : 16'bz;
    assign data1 = if1.cpu_rd ? 16'hBEEF : 16'bz;
    int n_pass = 0;
    int n_chk = 0;
    rsp_t sb[$];
    logic [15:0] model_reg = 16'd0;
    logic [15:0] last_rdata = 16'd0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic issue0(input string tag, input logic wr, input logic [5:0] a, input logic [15:0] d);
        int lat, n_wr, n_rd, n_drv, n_bad, n_addr;
        n_wr = 0; n_rd = 0; n_drv = 0; n_bad = 0; n_addr = 0;
        @(negedge clk);
        if0.req_valid = 1'b1;
        if0.req_write = wr;
        if0.req_address = a;
        if0.req_wdata = d;
        for (int i = 0; i < 50 && !if0.req_ready; i++) @(negedge clk);
        check({tag, "_ready"}, if0.req_ready, 1'b1);
        @(posedge clk);
        #1 if0.req_valid = 1'b0;
        lat = 1;
        while (1) begin
            if (if0.cpu_wr) n_wr++;
            if (if0.cpu_rd) n_rd++;
            if (!if0.cpu_rd && data0 !== 16'hFFFF) n_drv++;
            if (if0.cpu_wr && data0 !== d) n_bad++;
            if (if0.cpu_address == a) n_addr++;
            if (if0.rsp_valid || lat >= 40) break;
            @(posedge clk);
            #1 lat++;
        end
        if (wr) begin
            model_reg = d & 16'hFFFE;
            if (RB) last_rdata = model_reg;
            sb.push_back('{last_rdata, RB && (model_reg != d)});
        end else begin
            last_rdata = model_reg;
            sb.push_back('{model_reg, 1'b0});
        end
        check({tag, "_latency"}, lat, wr ? WLAT : 5);
        check({tag, "_wr_cycles"}, n_wr, wr ? 2 : 0);
        check({tag, "_rd_cycles"}, n_rd, wr ? (RB ? 2 : 0) : 2);
        check({tag, "_master_drive"}, n_drv, wr ? 4 : 0);
        check({tag, "_wdata_bad"}, n_bad, 0);
        check({tag, "_addr_cycles"}, n_addr, (wr && RB) ? 8 : 4);
    endtask
    task automatic consume0(input string tag);
        rsp_t e;
        @(negedge clk);
        check({tag, "_rsp_valid"}, if0.rsp_valid, 1'b1);
        check({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_rdata"}, if0.rsp_rdata, e.rdata);
            check({tag, "_error"}, if0.rsp_error, e.err);
        end
        if0.rsp_ready = 1'b1;
        @(posedge clk);
        #1 if0.rsp_ready = 1'b0;
        check({tag, "_released"}, if0.rsp_valid, 1'b0);
    endtask
    initial begin
        int n_unstable, n_ready, n_bus;
        logic [15:0] held;
        if0.req_valid = 0; if0.req_write = 0; if0.req_address = 0; if0.req_wdata = 0; if0.rsp_ready = 0;
        if1.req_valid = 0; if1.req_write = 0; if1.req_address = 0; if1.req_wdata = 0; if1.rsp_ready = 0;
        #12;
        check("rst_req_ready", if0.req_ready, 1'b0);
        check("rst_rsp_valid", if0.rsp_valid, 1'b0);
        check("rst_strobes", {if0.cpu_rd, if0.cpu_wr}, 2'b00);
        check("rst_address", if0.cpu_address, 6'd0);
        check("rst_data_z", data0, 16'hFFFF);
        check("rst_rdata", if0.rsp_rdata, 16'd0);
        check("rst_error", if0.rsp_error, 1'b0);
        check("rst_u1_ready", if1.req_ready, 1'b0);
        @(negedge clk) reset = 1'b1;
        issue0("wr_a5c3", 1'b1, 6'h05, 16'hA5C3);
        consume0("wr_a5c3");
        issue0("wr_1234", 1'b1, 6'h05, 16'h1234);
        consume0("wr_1234");
        issue0("rd_1234", 1'b0, 6'h05, 16'h0000);
        consume0("rd_1234");
        issue0("wr_00ff", 1'b1, 6'h0A, 16'h00FF);
        consume0("wr_00ff");
        issue0("rd_stall", 1'b0, 6'h0A, 16'h0000);
        n_unstable = 0; n_ready = 0; n_bus = 0;
        held = if0.rsp_rdata;
        if0.req_write = 1'b1; if0.req_address = 6'h05; if0.req_wdata = 16'h5555;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!if0.rsp_valid || if0.rsp_rdata !== held || if0.rsp_error !== 1'b0) n_unstable++;
            if (if0.req_ready) n_ready++;
            if (if0.cpu_rd || if0.cpu_wr || if0.cpu_address != 6'd0 || data0 !== 16'hFFFF) n_bus++;
            if0.req_valid = (i % 2 == 0);
        end
        if0.req_valid = 1'b0;
        check("stall_unstable", n_unstable, 0);
        check("stall_ready", n_ready, 0);
        check("stall_bus", n_bus, 0);
        consume0("rd_stall");
        issue0("rd_post_stall", 1'b0, 6'h0A, 16'h0000);
        consume0("rd_post_stall");
        @(negedge clk);
        if0.req_valid = 1'b1; if0.req_write = 1'b1; if0.req_address = 6'h21; if0.req_wdata = 16'hDEAD;
        @(posedge clk);
        #1 if0.req_valid = 1'b0;
        @(posedge clk);
        #1 check("abort_in_strobe", if0.cpu_wr, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_wr", if0.cpu_wr, 1'b0);
        check("abort_data_z", data0, 16'hFFFF);
        check("abort_rsp_valid", if0.rsp_valid, 1'b0);
        check("abort_req_ready", if0.req_ready, 1'b0);
        check("abort_rdata", if0.rsp_rdata, 16'd0);
        last_rdata = 16'd0;
        @(negedge clk) reset = 1'b1;
        #1 check("release_ready", if0.req_ready, 1'b1);
        issue0("wr_post_rst", 1'b1, 6'h21, 16'h77AA);
        consume0("wr_post_rst");
        issue0("rd_post_rst", 1'b0, 6'h21, 16'h0000);
        consume0("rd_post_rst");
        @(negedge clk);
        if1.req_valid = 1'b1; if1.req_write = 1'b0; if1.req_address = 6'h11;
        check("u1_ready", if1.req_ready, 1'b1);
        @(posedge clk);
        #1 if1.req_valid = 1'b0;
        check("u1_rd_after_accept", if1.cpu_rd, 1'b1);
        check("u1_address", if1.cpu_address, 6'h11);
        check("u1_not_early", if1.rsp_valid, 1'b0);
        @(posedge clk);
        #1 check("u1_latency2", if1.rsp_valid, 1'b1);
        check("u1_rd_drop", if1.cpu_rd, 1'b0);
        check("u1_rdata", if1.rsp_rdata, 16'hBEEF);
        check("u1_error", if1.rsp_error, 1'b0);
        if1.rsp_ready = 1'b1;
        @(posedge clk);
        #1 if1.rsp_ready = 1'b0;
        check("u1_released", if1.rsp_valid, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end
endmodule
